// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Matrix keypad scanner. Drives one active-low column at a time, samples the
//   synchronised rows once per column dwell, debounces every key with its own
//   scan counter and queues debounced press/release events in a small FIFO.
//
// Ports
//   clk_i            system clock
//   reset_i          asynchronous active-high reset
//   row_i            raw row lines, active-low, asynchronous to clk_i
//   column_o         column drive, active-low, exactly one bit low
//   keys_down_o      debounced level per key (index = row*COLS + col)
//   event_valid_o    FIFO head holds an event
//   event_ack_i      consumer pops the head while event_valid_o is high
//   event_pos_o      head key position
//   event_release_o  head type: 0 = press, 1 = release
//   overflow_o       sticky: an event was dropped because the FIFO was full
module keypad_scanner #(
  parameter int ROWS           = 3,
  parameter int COLS           = 3,
  parameter int SCAN_DIV       = 8192,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 4,
  localparam int POS_W         = $clog2(ROWS*COLS)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [ROWS-1:0]      row_i,
  output logic [COLS-1:0]      column_o,
  output logic [ROWS*COLS-1:0] keys_down_o,
  output logic                 event_valid_o,
  input  logic                 event_ack_i,
  output logic [POS_W-1:0]     event_pos_o,
  output logic                 event_release_o,
  output logic                 overflow_o
);

  localparam int NKEYS = ROWS*COLS;
  localparam int COL_W = $clog2(COLS);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS+1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [ROWS-1:0]  row_s1_q, row_s2_q;
  logic [ROWS-1:0]  pressed;
  logic [COL_W-1:0] col_q, col_d;
  logic [DIV_W-1:0] dwell_q, dwell_d;
  logic             sample;
  logic [CNT_W-1:0] cnt_q [NKEYS];
  logic [CNT_W-1:0] cnt_d [NKEYS];
  logic [NKEYS-1:0] keys_q, keys_d, pend_q, pend_d;
  logic             push_valid;
  logic [POS_W-1:0] push_pos;
  logic             push_rel;

  logic [POS_W-1:0]      fpos_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] frel_q;
  logic [PTR_W-1:0]      rd_q, wr_q;
  logic [PTR_W:0]        count_q;
  logic                  ovf_q;
  logic                  pop, full, accept;

  // Synchroniser resets to the idle (high) level so no key looks pressed.
  assign pressed = ~row_s2_q;

  // Dwell timer counts down; the terminal count is the sample cycle.
  assign sample = (dwell_q == '0);

  always_comb begin
    dwell_d = dwell_q - 1'b1;
    col_d   = col_q;
    if (sample) begin
      dwell_d = DIV_W'(SCAN_DIV-1);
      col_d   = (col_q == COL_W'(COLS-1)) ? '0 : col_q + 1'b1;
    end
  end

  always_comb begin
    column_o        = '1;
    column_o[col_q] = 1'b0;
  end

  // Serialiser and per-key debounce. The serialiser clears its bit first so a
  // sample setting a new pending bit on the same cycle is never lost; the
  // SCAN_DIV bound keeps all bits of one sample drained before the next.
  always_comb begin
    logic [POS_W-1:0] k;
    k          = '0;
    cnt_d      = cnt_q;
    keys_d     = keys_q;
    pend_d     = pend_q;
    push_valid = 1'b0;
    push_pos   = '0;
    for (int i = NKEYS-1; i >= 0; i--) begin
      if (pend_q[i]) begin
        push_valid = 1'b1;
        push_pos   = POS_W'(i);
      end
    end
    push_rel = ~keys_q[push_pos];
    if (push_valid) pend_d[push_pos] = 1'b0;

    if (sample) begin
      for (int r = 0; r < ROWS; r++) begin
        k = POS_W'(r*COLS) + POS_W'(col_q);
        if (pressed[r] == keys_q[k]) begin
          cnt_d[k] = '0;
        end else if (cnt_q[k] == CNT_W'(DEBOUNCE_SCANS-1)) begin
          cnt_d[k]  = '0;
          keys_d[k] = ~keys_q[k];
          pend_d[k] = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      row_s1_q <= '1;
      row_s2_q <= '1;
      col_q    <= '0;
      dwell_q  <= DIV_W'(SCAN_DIV-1);
      keys_q   <= '0;
      pend_q   <= '0;
      for (int i = 0; i < NKEYS; i++) cnt_q[i] <= '0;
    end else begin
      row_s1_q <= row_i;
      row_s2_q <= row_s1_q;
      col_q    <= col_d;
      dwell_q  <= dwell_d;
      keys_q   <= keys_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
    end
  end

  // Event FIFO. A pop frees a slot on the same edge, so push+pop while full
  // is accepted without overflow.
  assign pop    = event_valid_o & event_ack_i;
  assign full   = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign accept = push_valid & (~full | pop);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      frel_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fpos_q[i] <= '0;
    end else begin
      if (accept) begin
        fpos_q[wr_q] <= push_pos;
        frel_q[wr_q] <= push_rel;
        wr_q         <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (accept && !pop)      count_q <= count_q + 1'b1;
      else if (!accept && pop) count_q <= count_q - 1'b1;
      if (push_valid && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign event_valid_o   = (count_q != '0);
  assign event_pos_o     = event_valid_o ? fpos_q[rd_q] : '0;
  assign event_release_o = event_valid_o & frel_q[rd_q];
  assign keys_down_o     = keys_q;
  assign overflow_o      = ovf_q;

endmodule
